reaction_timer_ctrl: RTL and testbench
======================================

Name: reaction_timer_ctrl

Overview:
- Controller that sequences the lab's millisecond prescaler and elapsed-time counters into a reaction-time measurement.
- On start, waits a pseudo-random delay, lights the prompt LED, then measures milliseconds until the player presses the button.
- Reports the result, or flags a false start if the button is pressed before the LED comes on.
- Sits between the board's debounced pushbutton/switch inputs and the display decoder.

Parameters:
- TICKS_PER_MS, 50000, clk cycles per millisecond (50 MHz board clock).
- DELAY_BASE_MS, 1000, minimum prompt delay in ms.
- RAND_BITS, 10, number of LFSR bits added to the base delay (0..2^RAND_BITS-1 ms).
- MAX_MS, 9999, saturation/timeout value for the result.
- MSBITS, $clog2(MAX_MS+1), width of ms values.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_start  input  1  single-cycle start pulse
- i_button  input  1  debounced, synchronized button level, 1 = pressed
- o_led  output  1  prompt LED, high only in MEASURE
- o_busy  output  1  high in WAIT_DELAY and MEASURE
- o_delay_ms  output  MSBITS  delay target latched at start
- o_result  output  MSBITS  measured reaction time in ms
- o_valid  output  1  o_result holds a completed measurement
- o_false_start  output  1  last attempt ended in a false start

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; prescaler and elapsed counters 0; button history register 0; LFSR = 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk; never reaches 0.
- Press = rising edge of i_button (i_button & ~button_q). A button held through start is not a press until it is released and pressed again.
- Prescaler: counts 0..TICKS_PER_MS-1 and wraps. ms_tick is high for the one cycle where count == TICKS_PER_MS-1. It runs only in WAIT_DELAY and MEASURE and is cleared on entry to either state.
- Elapsed counter: increments on ms_tick and is cleared on entry to WAIT_DELAY and MEASURE.
- IDLE / DONE / FALSE_START, on i_start:
  - Next state is WAIT_DELAY.
  - o_delay_ms <= DELAY_BASE_MS + LFSR[RAND_BITS-1:0], using the current-cycle LFSR value.
  - o_valid <= 0, o_false_start <= 0. o_result holds its old value.
- WAIT_DELAY:
  - Press -> FALSE_START with o_false_start <= 1, o_led stays 0. Press wins over a simultaneous delay expiry.
  - Otherwise, ms_tick while elapsed == o_delay_ms-1 -> MEASURE. o_led = 1 from the first MEASURE cycle.
- MEASURE:
  - Press -> DONE with o_result <= elapsed (pre-increment value) and o_valid <= 1. Press wins over a same-cycle ms_tick.
  - ms_tick while elapsed == MAX_MS-1 -> DONE with o_result <= MAX_MS and o_valid <= 1 (timeout).
- DONE and FALSE_START: outputs hold until the next i_start. o_led = 0.
- i_start is ignored in WAIT_DELAY and MEASURE; a second start does not restart the attempt.
- Latency:
  - i_start to o_busy = 1 is 1 cycle.
  - Press to o_valid/o_false_start = 1 is 1 cycle after the edge is seen.
  - o_led falls in the same cycle o_valid rises.
- Reset asserted mid-attempt returns to the reset values immediately, regardless of clk.
- All arithmetic is unsigned at MSBITS width. Parameters must satisfy DELAY_BASE_MS + 2^RAND_BITS - 1 <= MAX_MS; this is checked with an elaboration-time assertion.

Test Plan:
- Bench parameters: TICKS_PER_MS=4, DELAY_BASE_MS=2, RAND_BITS=2, MAX_MS=9.
- Reset, then i_start -> o_busy=1 next cycle. o_delay_ms in 2..5 and equal to 2 + LFSR[1:0] sampled in the start cycle. o_led rises exactly 4*o_delay_ms cycles after WAIT_DELAY entry.
- Press 3 ms plus 1 cycle after o_led rises -> o_result=3, o_valid=1, o_led=0, o_busy=0. Outputs hold for 100 cycles.
- Press during WAIT_DELAY -> o_false_start=1, o_valid=0, o_led never asserted. A following i_start clears o_false_start.
- No press in MEASURE -> after 36 cycles o_result=9 (MAX_MS) and o_valid=1. A press landing on the same cycle as a ms_tick yields the pre-increment value.
- Button held high across i_start -> no false start until released and re-pressed. i_start pulsed during MEASURE -> ignored, o_delay_ms unchanged.
- Async reset asserted mid-MEASURE between clock edges -> all outputs 0 immediately. After release, state is IDLE and the next i_start behaves normally.

Source files
------------

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game controller: random prompt delay, LED prompt, and
// millisecond measurement of the player's response or a false start.
module reaction_timer_ctrl #(
    parameter int TICKS_PER_MS  = 50000,
    parameter int DELAY_BASE_MS = 1000,
    parameter int RAND_BITS     = 10,
    parameter int MAX_MS        = 9999,
    parameter int MSBITS        = $clog2(MAX_MS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_button,
    output logic              o_led,
    output logic              o_busy,
    output logic [MSBITS-1:0] o_delay_ms,
    output logic [MSBITS-1:0] o_result,
    output logic              o_valid,
    output logic              o_false_start
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0]     TICK_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [MSBITS-1:0] BASE_V    = MSBITS'(DELAY_BASE_MS);
    localparam logic [MSBITS-1:0] MAX_V     = MSBITS'(MAX_MS);
    localparam logic [MSBITS-1:0] MAX_M1    = MSBITS'(MAX_MS - 1);

    if (DELAY_BASE_MS + (1 << RAND_BITS) - 1 > MAX_MS) begin : g_param_chk
        $error("reaction_timer_ctrl: longest prompt delay exceeds MAX_MS");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_MEAS, S_DONE, S_FALSE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              btn_q;
    logic [PW-1:0]     pre_q, pre_d;
    logic [MSBITS-1:0] el_q, el_d;
    logic [MSBITS-1:0] delay_q, delay_d;
    logic [MSBITS-1:0] result_q, result_d;
    logic              valid_q, valid_d;
    logic              fs_q, fs_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              press;
    logic              ms_tick;

    assign press   = i_button & ~btn_q;
    assign ms_tick = (pre_q == TICK_LAST);

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        el_d     = el_q;
        delay_d  = delay_q;
        result_d = result_q;
        valid_d  = valid_q;
        fs_d     = fs_q;
        lfsr_d   = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        if (state_q == S_WAIT || state_q == S_MEAS) begin
            pre_d = ms_tick ? '0 : pre_q + PW'(1);
            el_d  = ms_tick ? el_q + MSBITS'(1) : el_q;
        end

        unique case (state_q)
            S_IDLE, S_DONE, S_FALSE: begin
                if (i_start) begin
                    state_d = S_WAIT;
                    delay_d = BASE_V + MSBITS'(lfsr_q[RAND_BITS-1:0]);
                    valid_d = 1'b0;
                    fs_d    = 1'b0;
                    pre_d   = '0;
                    el_d    = '0;
                end
            end
            S_WAIT: begin
                // A press always beats a delay expiry in the same cycle
                if (press) begin
                    state_d = S_FALSE;
                    fs_d    = 1'b1;
                end else if (ms_tick && el_q == delay_q - MSBITS'(1)) begin
                    state_d = S_MEAS;
                    pre_d   = '0;
                    el_d    = '0;
                end
            end
            S_MEAS: begin
                if (press) begin
                    state_d  = S_DONE;
                    result_d = el_q;
                    valid_d  = 1'b1;
                end else if (ms_tick && el_q == MAX_M1) begin
                    state_d  = S_DONE;
                    result_d = MAX_V;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        led_d  = (state_d == S_MEAS);
        busy_d = (state_d == S_WAIT) || (state_d == S_MEAS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lfsr_q   <= 16'hACE1;
            btn_q    <= 1'b0;
            pre_q    <= '0;
            el_q     <= '0;
            delay_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            btn_q    <= i_button;
            pre_q    <= pre_d;
            el_q     <= el_d;
            delay_q  <= delay_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
        end
    end

    assign o_led         = led_q;
    assign o_busy        = busy_q;
    assign o_delay_ms    = delay_q;
    assign o_result      = result_q;
    assign o_valid       = valid_q;
    assign o_false_start = fs_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Randomized bench for reaction_timer_ctrl; expectations come from
// millisecond arithmetic on cycle counts, not from an FSM copy.
module tb_reaction_timer_ctrl;

    localparam int TPM   = 4;
    localparam int BASE  = 2;
    localparam int RB    = 2;
    localparam int MAXMS = 9;
    localparam int MSB   = $clog2(MAXMS + 1);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           i_start = 1'b0;
    logic           i_button = 1'b0;
    logic           o_led, o_busy, o_valid, o_false_start;
    logic [MSB-1:0] o_delay_ms, o_result;

    int          n_tests = 0;
    int          n_fail = 0;
    int          last_result = 0;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    reaction_timer_ctrl #(
        .TICKS_PER_MS (TPM),
        .DELAY_BASE_MS(BASE),
        .RAND_BITS    (RB),
        .MAX_MS       (MAXMS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .i_button     (i_button),
        .o_led        (o_led),
        .o_busy       (o_busy),
        .o_delay_ms   (o_delay_ms),
        .o_result     (o_result),
        .o_valid      (o_valid),
        .o_false_start(o_false_start)
    );

    // Free-running reference LFSR: x^16+x^14+x^13+x^11, shifted every clock
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else m_lfsr <= {m_lfsr[14:0],
                        m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns the expected delay in ms
    task automatic do_start(output int d);
        logic [15:0] l;
        l = m_lfsr;
        d = BASE + int'(l[RB-1:0]);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 1);
        check("delay_ms", 32'(o_delay_ms), d);
        check("delay_range", 32'(o_delay_ms >= 2 && o_delay_ms <= 5), 1);
        check("valid_cleared", 32'(o_valid), 0);
        check("fs_cleared", 32'(o_false_start), 0);
        check("result_held", 32'(o_result), last_result);
    endtask

    // Returns at the negedge right after the first MEASURE edge
    task automatic wait_led(input int d);
        int early = 0;
        repeat (4 * d - 1) begin
            @(negedge clk);
            if (o_led !== 1'b0) early++;
        end
        check("led_early", early, 0);
        @(negedge clk);
        check("led_rise", 32'(o_led), 1);
        check("busy_measure", 32'(o_busy), 1);
    endtask

    // Press sampled n edges after MEASURE entry; n > 36 means no press.
    // 'done' edges have already elapsed since entry.
    task automatic press_measure(input int n, input int done);
        int exp;
        if (n > 4 * MAXMS) begin
            repeat (4 * MAXMS - 1 - done) @(negedge clk);
            check("no_early_timeout", 32'(o_valid), 0);
            @(negedge clk);
            exp = MAXMS;
        end else begin
            repeat (n - 1 - done) @(negedge clk);
            i_button = 1'b1;
            @(negedge clk);
            exp = (n - 1) / TPM;
        end
        check("result", 32'(o_result), exp);
        check("valid", 32'(o_valid), 1);
        check("led_off_done", 32'(o_led), 0);
        check("busy_off_done", 32'(o_busy), 0);
        last_result = exp;
        i_button = 1'b0;
    endtask

    // Press sampled j edges after WAIT_DELAY entry, j in 1..4*d
    task automatic false_start(input int j);
        int led_seen = 0;
        repeat (j - 1) begin
            @(negedge clk);
            if (o_led !== 1'b0) led_seen++;
        end
        i_button = 1'b1;
        @(negedge clk);
        check("led_never_fs", led_seen, 0);
        check("false_start", 32'(o_false_start), 1);
        check("valid_fs", 32'(o_valid), 0);
        check("led_fs", 32'(o_led), 0);
        check("busy_fs", 32'(o_busy), 0);
        i_button = 1'b0;
    endtask

    initial begin
        int d, bad, mode, n;
        #1;
        check("rst_led", 32'(o_led), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_delay", 32'(o_delay_ms), 0);
        check("rst_result", 32'(o_result), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_fs", 32'(o_false_start), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(o_busy), 0);

        do_start(d);
        wait_led(d);
        press_measure(13, 0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_result !== 4'd3 || o_valid !== 1'b1 ||
                o_led !== 1'b0 || o_busy !== 1'b0) bad++;
        end
        check("hold_100", bad, 0);

        do_start(d);
        false_start($urandom_range(1, 4 * d - 1));
        do_start(d);
        false_start(4 * d);

        do_start(d);
        wait_led(d);
        press_measure(4 * MAXMS + 1, 0);

        do_start(d);
        wait_led(d);
        press_measure(8, 0);

        i_button = 1'b1;
        @(negedge clk);
        do_start(d);
        repeat (4 * d - 2) @(negedge clk);
        check("held_no_fs", 32'(o_false_start), 0);
        check("held_busy", 32'(o_busy), 1);
        i_button = 1'b0;
        @(negedge clk);
        i_button = 1'b1;
        @(negedge clk);
        check("repress_fs", 32'(o_false_start), 1);
        check("repress_led", 32'(o_led), 0);
        i_button = 1'b0;

        do_start(d);
        wait_led(d);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("start_ignored_delay", 32'(o_delay_ms), d);
        check("start_ignored_led", 32'(o_led), 1);
        check("start_ignored_busy", 32'(o_busy), 1);
        press_measure(13, 2);

        do_start(d);
        wait_led(d);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_led", 32'(o_led), 0);
        check("arst_busy", 32'(o_busy), 0);
        check("arst_delay", 32'(o_delay_ms), 0);
        check("arst_result", 32'(o_result), 0);
        check("arst_valid", 32'(o_valid), 0);
        check("arst_fs", 32'(o_false_start), 0);
        last_result = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_idle", 32'(o_busy), 0);
        do_start(d);
        wait_led(d);
        press_measure(13, 0);

        repeat (10) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            mode = $urandom_range(0, 2);
            do_start(d);
            if (mode == 1) begin
                false_start($urandom_range(1, 4 * d));
            end else begin
                wait_led(d);
                n = (mode == 0) ? $urandom_range(1, 4 * MAXMS + 4)
                                : 4 * MAXMS + 1;
                press_measure(n, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
